sr_imem_loader: RTL

- Responder end of the CPU instruction-fetch interface: returns imData for the word address presented on imAddr in the same cycle.
- Provides a byte-serial valid/ready load port that assembles little-endian bytes into 32-bit words and writes them to the program RAM.
- Holds the CPU in reset (cpu_rst_n low) for the whole load, then releases it so execution starts from word 0.
- Sits between the top level/debug loader and the CPU's imAddr/imData pins.

---
 rtl/sr_imem_pkg.sv | 34 +++
 rtl/sr_imem_loader_if.sv | 30 +++
 rtl/sr_imem_ram.sv | 29 ++
 rtl/sr_imem_loader.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sr_imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, fetch filler
// word, word/byte geometry and a byte-lane insert helper.
package sr_imem_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    // addi x0,x0,0 -- fed to the CPU for blocked or out-of-range fetches
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANES  = WORD_W / BYTE_W;

    // Replace one little-endian byte lane of a word
    function automatic logic [WORD_W-1:0] put_byte(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        lane,
        input logic [BYTE_W-1:0] data
    );
        logic [WORD_W-1:0] w;
        w = word;
        case (lane)
            2'd0:    w[0*BYTE_W +: BYTE_W] = data;
            2'd1:    w[1*BYTE_W +: BYTE_W] = data;
            2'd2:    w[2*BYTE_W +: BYTE_W] = data;
            default: w[3*BYTE_W +: BYTE_W] = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sr_imem_loader_if.sv
// Fetch + byte-serial load bus of the instruction-memory loader.
//   master: CPU fetch side and loader source (drives imAddr, ld_start/end/valid/data)
//   slave : sr_imem_loader (drives imData, ld_ready, ld_done, ld_words)
interface sr_imem_loader_if
    import sr_imem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6
) ();

    logic [WORD_W-1:0] imAddr;
    logic [WORD_W-1:0] imData;
    logic              ld_start;
    logic              ld_end;
    logic              ld_valid;
    logic [BYTE_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic [ADDR_WIDTH:0] ld_words;

    modport master (
        output imAddr, ld_start, ld_end, ld_valid, ld_data,
        input  imData, ld_ready, ld_done, ld_words
    );

    modport slave (
        input  imAddr, ld_start, ld_end, ld_valid, ld_data,
        output imData, ld_ready, ld_done, ld_words
    );

endinterface

// File: rtl/sr_imem_ram.sv
// Program RAM: 2**ADDR_WIDTH x 32, one synchronous write port, one async read port.
// Ports: clk; we/waddr/wdata write port; raddr -> rdata combinational read.
module sr_imem_ram
    import sr_imem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WORD_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sr_imem_loader.sv
// Instruction-memory responder with byte-serial program loader.
// Ports: clk, rst (async, active high); cpu_rst_n holds the CPU in reset while
// loading; bus (slave) carries the CPU fetch path (imAddr -> imData, combinational)
// and the valid/ready byte load port with ld_start/ld_end/ld_done/ld_words.
module sr_imem_loader
    import sr_imem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    output logic          cpu_rst_n,
    sr_imem_loader_if.slave bus
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    state_t                  state;
    logic [1:0]              byte_cnt;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [WORD_W-1:0]       asm_word;
    logic                    done_q;
    logic [CNT_W-1:0]        words_q;

    logic                    ready_c;
    logic                    accept_c;
    logic [1:0]              cnt_next_c;
    logic [WORD_W-1:0]       cur_word_c;
    logic                    wr_c;
    logic                    full_c;
    logic [WORD_W-1:0]       rd_data_c;

    // Byte acceptance and word-write decision for this cycle
    always_comb begin
        ready_c    = 1'b0;
        accept_c   = 1'b0;
        cnt_next_c = byte_cnt;
        cur_word_c = asm_word;
        wr_c       = 1'b0;
        full_c     = 1'b0;

        ready_c    = (state == ST_LOAD) && !bus.ld_start;
        accept_c   = bus.ld_valid && ready_c;
        cnt_next_c = byte_cnt + 2'(accept_c);
        if (accept_c) begin
            cur_word_c = put_byte(asm_word, byte_cnt, bus.ld_data);
        end
        // Unfilled lanes are already zero because asm_word clears after each write
        wr_c   = (accept_c && (byte_cnt == 2'd3)) ||
                 (ready_c && bus.ld_end && (cnt_next_c != 2'd0));
        full_c = wr_c && (waddr == '1);
    end

    // Session FSM, assembler and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            cpu_rst_n <= 1'b0;
            done_q    <= 1'b0;
            words_q   <= '0;
            byte_cnt  <= '0;
            waddr     <= '0;
            asm_word  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    cpu_rst_n <= !bus.ld_start;
                    if (bus.ld_start) begin
                        state    <= ST_LOAD;
                        waddr    <= '0;
                        byte_cnt <= '0;
                        words_q  <= '0;
                        asm_word <= '0;
                    end
                end
                default: begin
                    cpu_rst_n <= 1'b0;
                    if (bus.ld_start) begin
                        waddr    <= '0;
                        byte_cnt <= '0;
                        words_q  <= '0;
                        asm_word <= '0;
                    end else begin
                        if (accept_c) begin
                            byte_cnt <= cnt_next_c;
                            asm_word <= cur_word_c;
                        end
                        if (wr_c) begin
                            asm_word <= '0;
                            words_q  <= words_q + CNT_W'(1);
                            // Last word pins the address; the session ends here
                            if (!full_c) begin
                                waddr <= waddr + ADDR_WIDTH'(1);
                            end
                        end
                        if (full_c || bus.ld_end) begin
                            state    <= ST_RUN;
                            done_q   <= 1'b1;
                            byte_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

    sr_imem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_c),
        .waddr (waddr),
        .wdata (cur_word_c),
        .raddr (bus.imAddr[ADDR_WIDTH-1:0]),
        .rdata (rd_data_c)
    );

    // Fetches are blocked during a load and outside the RAM window
    assign bus.imData   = ((state == ST_RUN) && (bus.imAddr[WORD_W-1:ADDR_WIDTH] == '0))
                          ? rd_data_c : NOP_WORD;
    assign bus.ld_ready = ready_c;
    assign bus.ld_done  = done_q;
    assign bus.ld_words = words_q;

endmodule
